// File: rtl/conv3d_asym_kernel_mac_engine.sv
// Streaming MAC for one 3D-conv output point: TAPS products, optional bias, round, saturate.
// Latency: result valid two cycles after the final tap is accepted (POST, then OUT).
// Backpressure: in_ready low during POST/OUT; the result is held until out_valid && out_ready.
module conv3d_asym_kernel_mac_engine #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 48,
  parameter int OUT_W    = 32,
  parameter int KD       = 3,
  parameter int KH       = 5,
  parameter int KW       = 7,
  parameter int CIN      = 4,
  parameter int SHIFT    = 8,
  parameter int USE_BIAS = 0,
  localparam int TAPS    = KD * KH * KW * CIN,
  localparam int IDX_W   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] in_weight,
  input  logic                     in_last,
  input  logic signed [OUT_W-1:0]  bias_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     err_last,
  output logic [IDX_W-1:0]         tap_idx
);

  localparam int PW     = 2 * DATA_W;
  // Two guard bits so acc + shifted bias + rounding constant cannot wrap.
  localparam int EXT_W  = ACC_W + 2;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EXT_W-1:0] RND =
    (SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  generate
    if (KD < 1 || KH < 1 || KW < 1 || CIN < 1) begin : g_bad_kernel
      $error("kernel dimensions and CIN must be >= 1");
    end
    if (ACC_W < 2 * DATA_W + $clog2(TAPS) + 1) begin : g_bad_acc
      $error("ACC_W too small for TAPS full-precision products");
    end
    if (SHIFT < 0 || SHIFT > ACC_W - OUT_W) begin : g_bad_shift
      $error("SHIFT must lie in 0..ACC_W-OUT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_POST,
    S_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [OUT_W-1:0]   bias_q, bias_d;
  logic [IDX_W-1:0]          tap_idx_q, tap_idx_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;
  logic                      err_q, err_d;

  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic                      take;
  logic                      is_final;

  logic signed [EXT_W-1:0]   acc_ext;
  logic signed [EXT_W-1:0]   bias_ext;
  logic signed [EXT_W-1:0]   bias_term;
  logic signed [EXT_W-1:0]   sum;
  logic signed [EXT_W-1:0]   rounded;
  logic signed [OUT_W-1:0]   res_dat;
  logic                      res_sat;

  // Full-precision signed product, widened before multiply so no bits are lost.
  assign prod     = PW'(in_data) * PW'(in_weight);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign take      = in_valid && in_ready;
  assign is_final  = (tap_idx_q == IDX_W'(TAPS - 1));

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;
  assign err_last = err_q;
  assign tap_idx  = tap_idx_q;

  // Post-processing datapath: bias alignment, round-half-up, arithmetic shift.
  assign acc_ext   = {{2{acc_q[ACC_W-1]}}, acc_q};
  assign bias_ext  = {{(EXT_W-OUT_W){bias_q[OUT_W-1]}}, bias_q};
  assign bias_term = (USE_BIAS != 0) ? (bias_ext <<< SHIFT) : '0;
  assign sum       = acc_ext + bias_term;
  assign rounded   = (sum + RND) >>> SHIFT;

  // Clamp the rounded value into the signed OUT_W range and flag clipping.
  always_comb begin
    res_sat = 1'b0;
    res_dat = rounded[OUT_W-1:0];
    if (rounded > OUT_MAX) begin
      res_dat = OUT_MAX[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (rounded < OUT_MIN) begin
      res_dat = OUT_MIN[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  // Next-state and datapath updates; the window boundary comes from tap_idx only.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    tap_idx_d  = tap_idx_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          acc_d  = prod_ext;
          bias_d = bias_data;
          if (TAPS == 1) begin
            tap_idx_d = '0;
            state_d   = S_POST;
          end else begin
            tap_idx_d = IDX_W'(1);
            state_d   = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (take) begin
          acc_d = acc_q + prod_ext;
          if (is_final) begin
            tap_idx_d = '0;
            state_d   = S_POST;
          end else begin
            tap_idx_d = tap_idx_q + IDX_W'(1);
          end
        end
      end
      S_POST: begin
        out_data_d = res_dat;
        out_sat_d  = res_sat;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The producer's last marker is only cross-checked, never obeyed.
    if (take && (in_last != is_final)) begin
      err_d = 1'b1;
    end
  end

  // State and datapath registers; reset discards any partial sum or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      bias_q     <= '0;
      tap_idx_q  <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      tap_idx_q  <= tap_idx_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_conv3d_asym_kernel_mac_engine.sv
// Bench for the 3D-conv MAC engine: three instances share one tap stream.
// Instance 0: SHIFT=8 no bias; 1: SHIFT=0 no bias; 2: SHIFT=8 with bias.
// Results are compared against an arithmetic model of the window sum.
module tb_conv3d_asym_kernel_mac_engine;

  localparam int TAPS = 420;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_last;
  logic out_ready;
  logic signed [15:0] in_data;
  logic signed [15:0] in_weight;
  logic signed [31:0] bias_data;

  logic               o_rdy [3];
  logic               o_vld [3];
  logic signed [31:0] o_dat [3];
  logic               o_sat [3];
  logic               o_err [3];
  logic [8:0]         o_idx [3];

  logic signed [15:0] act [TAPS];
  logic signed [15:0] wt  [TAPS];
  logic signed [31:0] bs  [TAPS];

  int n_checks = 0;
  int n_errors = 0;
  bit err_exp  = 1'b0;

  always #5 clk = ~clk;

  conv3d_asym_kernel_mac_engine #(.SHIFT(8), .USE_BIAS(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .bias_data(bias_data), .out_valid(o_vld[0]), .out_ready(out_ready),
    .out_data(o_dat[0]), .out_sat(o_sat[0]), .err_last(o_err[0]),
    .tap_idx(o_idx[0])
  );

  conv3d_asym_kernel_mac_engine #(.SHIFT(0), .USE_BIAS(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .bias_data(bias_data), .out_valid(o_vld[1]), .out_ready(out_ready),
    .out_data(o_dat[1]), .out_sat(o_sat[1]), .err_last(o_err[1]),
    .tap_idx(o_idx[1])
  );

  conv3d_asym_kernel_mac_engine #(.SHIFT(8), .USE_BIAS(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .bias_data(bias_data), .out_valid(o_vld[2]), .out_ready(out_ready),
    .out_data(o_dat[2]), .out_sat(o_sat[2]), .err_last(o_err[2]),
    .tap_idx(o_idx[2])
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int shift_of(input int d);
    return (d == 1) ? 0 : 8;
  endfunction

  function automatic bit bias_of(input int d);
    return (d == 2);
  endfunction

  // Floor division by 2^sh, written without shifts.
  function automatic longint floor_div(input longint num, input int sh);
    longint den;
    longint q;
    den = 1;
    for (int k = 0; k < sh; k++) den = den * 2;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  // value = floor((acc + bias*2^sh + 2^sh/2) / 2^sh)
  function automatic longint model_val(input longint acc, input longint b,
                                       input int sh, input bit ub);
    longint scale;
    longint s;
    scale = 1;
    for (int k = 0; k < sh; k++) scale = scale * 2;
    s = acc + (ub ? b * scale : 64'sd0);
    if (sh > 0) s = s + scale / 2;
    return floor_div(s, sh);
  endfunction

  task automatic fill_const(input logic signed [15:0] a, input logic signed [15:0] w,
                            input logic signed [31:0] b);
    for (int i = 0; i < TAPS; i++) begin
      act[i] = a;
      wt[i]  = w;
      bs[i]  = b;
    end
  endtask

  task automatic fill_rand(input bit full, input logic signed [31:0] b);
    for (int i = 0; i < TAPS; i++) begin
      if (full) begin
        act[i] = 16'($urandom);
        wt[i]  = 16'($urandom);
      end else begin
        act[i] = 16'($urandom_range(0, 511)) - 16'sd256;
        wt[i]  = 16'($urandom_range(0, 511)) - 16'sd256;
      end
      bs[i] = (i == 0) ? b : 32'($urandom);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_vld%0d", d), o_vld[d], 0);
      chk($sformatf("rst_dat%0d", d), o_dat[d], 0);
      chk($sformatf("rst_sat%0d", d), o_sat[d], 0);
      chk($sformatf("rst_err%0d", d), o_err[d], 0);
      chk($sformatf("rst_idx%0d", d), o_idx[d], 0);
    end
    rst     = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_rdy%0d", d), o_rdy[d], 1);
    end
  endtask

  // Streams act/wt/bs as one window; in_last is raised on tap last_pos.
  task automatic run_window(input string name, input int last_pos,
                            input int hold, input int gap_pct);
    longint acc;
    longint r;
    longint exp_d [3];
    logic   exp_s [3];
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(act[i]) * longint'(wt[i]);
    for (int d = 0; d < 3; d++) begin
      r = model_val(acc, longint'(bs[0]), shift_of(d), bias_of(d));
      exp_s[d] = 1'b1;
      if (r > MAXV) exp_d[d] = MAXV;
      else if (r < MINV) exp_d[d] = MINV;
      else begin
        exp_d[d] = r;
        exp_s[d] = 1'b0;
      end
    end
    if (last_pos != TAPS - 1) err_exp = 1'b1;

    for (int i = 0; i < TAPS; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk($sformatf("%s_gap_idx", name), o_idx[0], i);
      end
      in_valid  = 1'b1;
      in_data   = act[i];
      in_weight = wt[i];
      in_last   = (i == last_pos);
      bias_data = bs[i];
      if (i == 0 || i == TAPS - 1) begin
        chk($sformatf("%s_rdy_t%0d", name, i), o_rdy[0], 1);
        chk($sformatf("%s_idx_t%0d", name, i), o_idx[0], i);
      end
      @(negedge clk);
    end

    // POST cycle
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (hold > 0) out_ready = 1'b0;
    chk($sformatf("%s_post_vld", name), o_vld[0], 0);
    chk($sformatf("%s_post_rdy", name), o_rdy[0], 0);
    @(negedge clk);

    // OUT: valid exactly two cycles after the final tap
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_vld%0d", name, d), o_vld[d], 1);
      chk($sformatf("%s_dat%0d", name, d), o_dat[d], exp_d[d]);
      chk($sformatf("%s_sat%0d", name, d), o_sat[d], exp_s[d]);
      chk($sformatf("%s_err%0d", name, d), o_err[d], err_exp);
      chk($sformatf("%s_idx%0d", name, d), o_idx[d], 0);
    end

    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      in_weight = 16'($urandom);
      @(negedge clk);
      chk($sformatf("%s_hold_vld", name), o_vld[0], 1);
      chk($sformatf("%s_hold_rdy", name), o_rdy[0], 0);
      chk($sformatf("%s_hold_dat0", name), o_dat[0], exp_d[0]);
      chk($sformatf("%s_hold_dat1", name), o_dat[1], exp_d[1]);
      chk($sformatf("%s_hold_idx", name), o_idx[0], 0);
    end

    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_done_vld", name), o_vld[0], 0);
    chk($sformatf("%s_done_rdy", name), o_rdy[0], 1);
  endtask

  task automatic run_reset_at(input int k);
    for (int i = 0; i < k; i++) begin
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      in_weight = 16'($urandom);
      in_last   = 1'b0;
      bias_data = 32'($urandom);
      @(negedge clk);
    end
    chk("mid_idx", o_idx[0], k);
    do_reset();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_weight = '0;
    bias_data = '0;
    out_ready = 1'b1;
    do_reset();

    fill_const(16'sd1, 16'sd1, 32'sd0);
    run_window("ones", TAPS - 1, 0, 0);

    fill_const(16'sd32767, 16'sd32767, 32'sd0);
    run_window("satpos", TAPS - 1, 0, 0);
    fill_const(-16'sd32768, 16'sd32767, 32'sd0);
    run_window("satneg", TAPS - 1, 0, 0);

    begin
      logic signed [15:0] rv [4];
      rv = '{-16'sd128, -16'sd129, 16'sd383, 16'sd384};
      for (int k = 0; k < 4; k++) begin
        fill_const(16'sd0, 16'sd1, 32'sd0);
        act[$urandom_range(0, TAPS - 1)] = rv[k];
        run_window($sformatf("round%0d", k), TAPS - 1, 0, 0);
      end
    end

    fill_const(16'sd1, 16'sd1, -32'sd5);
    run_window("bias", TAPS - 1, 0, 0);
    for (int i = 1; i < TAPS; i++) bs[i] = 32'($urandom);
    run_window("bias_chg", TAPS - 1, 0, 10);

    fill_const(16'sd1, 16'sd1, 32'sd7);
    run_window("hold", TAPS - 1, 10, 0);
    fill_rand(1'b0, 32'sd100);
    run_window("after_hold", TAPS - 1, 0, 0);

    fill_rand(1'b0, -32'sd3);
    run_window("badlast", 100, 0, 0);
    fill_const(16'sd2, 16'sd3, 32'sd0);
    run_window("sticky", TAPS - 1, 0, 0);

    run_reset_at(200);
    fill_const(16'sd1, 16'sd1, 32'sd0);
    run_window("after_rst", TAPS - 1, 0, 0);

    for (int n = 0; n < 6; n++) begin
      fill_rand(n[0], 32'($urandom));
      run_window($sformatf("rnd%0d", n), TAPS - 1, $urandom_range(0, 4), 15);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
